// File: rtl/match_pkg.sv
// Shared types and constants for the descriptor match scheduler.
package match_pkg;

  localparam int unsigned RES_IDX_W = 10;
  localparam int unsigned DESC_W    = 148;
  localparam int unsigned COOR_MSB  = 147;
  localparam int unsigned COOR_LSB  = 128;
  localparam int unsigned COOR_W    = COOR_MSB - COOR_LSB + 1;
  localparam int unsigned HD_W      = 8;

  typedef enum logic [2:0] {
    IDLE,
    MAIN_RD,
    CLEAR,
    STREAM,
    DRAIN,
    EMIT,
    NEXT,
    FIN
  } state_e;

  typedef struct packed {
    logic [RES_IDX_W-1:0] main_idx;
    logic [RES_IDX_W-1:0] slave_idx;
    logic [COOR_W-1:0]    main_coor;
    logic [COOR_W-1:0]    slave_coor;
    logic [HD_W-1:0]      hd;
  } res_t;

endpackage

// File: rtl/match_scheduler.sv
// Sequences one match_core over every main descriptor against the full slave set
// and emits thresholded best-match results on a valid/ready port.
module match_scheduler
  import match_pkg::*;
#(
  parameter int unsigned     IDX_W     = RES_IDX_W,
  parameter logic [HD_W-1:0] HD_THRESH = 8'd64,
  parameter int unsigned     DESC_W    = match_pkg::DESC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [IDX_W-1:0]  n_main,
  input  logic [IDX_W-1:0]  n_slave,
  output logic              main_rd,
  output logic [IDX_W-1:0]  main_addr,
  input  logic [DESC_W-1:0] main_rdata,
  output logic              slave_rd,
  output logic [IDX_W-1:0]  slave_addr,
  input  logic [DESC_W-1:0] slave_rdata,
  output logic              core_en,
  output logic              core_clear,
  output logic [DESC_W-1:0] core_main,
  output logic [DESC_W-1:0] core_slave,
  input  logic [IDX_W-1:0]  core_index,
  input  logic [COOR_W-1:0] core_coor,
  input  logic [HD_W-1:0]   core_min_hd,
  input  logic              core_done,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [IDX_W-1:0]  res_main_idx,
  output logic [IDX_W-1:0]  res_slave_idx,
  output logic [COOR_W-1:0] res_main_coor,
  output logic [COOR_W-1:0] res_slave_coor,
  output logic [HD_W-1:0]   res_hd,
  output logic [IDX_W-1:0]  res_cnt,
  output logic              busy,
  output logic              done
);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  n_main_q, n_main_d;
  logic [IDX_W-1:0]  n_slave_q, n_slave_d;
  logic [IDX_W-1:0]  main_idx_q, main_idx_d;
  logic [IDX_W-1:0]  res_cnt_q, res_cnt_d;
  logic [IDX_W-1:0]  main_addr_q, main_addr_d;
  logic [IDX_W-1:0]  slave_addr_q, slave_addr_d;
  logic              main_rd_q, main_rd_d;
  logic              slave_rd_q, slave_rd_d;
  logic              core_en_q, core_en_d;
  logic              core_clear_q, core_clear_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              res_valid_q, res_valid_d;
  logic [DESC_W-1:0] core_main_q, core_main_d;
  res_t              res_q, res_d;

  // Next-state and registered-output logic; outputs are set on the transition
  // into the state that owns them so they are high for exactly that state.
  always_comb begin
    state_d      = state_q;
    n_main_d     = n_main_q;
    n_slave_d    = n_slave_q;
    main_idx_d   = main_idx_q;
    res_cnt_d    = res_cnt_q;
    main_addr_d  = main_addr_q;
    slave_addr_d = slave_addr_q;
    main_rd_d    = 1'b0;
    slave_rd_d   = 1'b0;
    core_en_d    = slave_rd_q;
    core_clear_d = 1'b0;
    busy_d       = busy_q;
    done_d       = 1'b0;
    res_valid_d  = res_valid_q;
    core_main_d  = core_main_q;
    res_d        = res_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          n_main_d   = n_main;
          n_slave_d  = n_slave;
          main_idx_d = '0;
          res_cnt_d  = '0;
          busy_d     = 1'b1;
          if (n_main == '0) begin
            state_d = FIN;
          end else begin
            state_d     = MAIN_RD;
            main_rd_d   = 1'b1;
            main_addr_d = '0;
          end
        end
      end
      MAIN_RD: begin
        state_d      = CLEAR;
        core_clear_d = 1'b1;
      end
      CLEAR: begin
        core_main_d = main_rdata;
        if (n_slave_q == '0) begin
          state_d = NEXT;
        end else begin
          state_d      = STREAM;
          slave_rd_d   = 1'b1;
          slave_addr_d = '0;
        end
      end
      STREAM: begin
        if (slave_addr_q == n_slave_q - IDX_W'(1)) begin
          state_d = DRAIN;
        end else begin
          slave_rd_d   = 1'b1;
          slave_addr_d = slave_addr_q + IDX_W'(1);
        end
      end
      DRAIN: begin
        if (core_done) begin
          res_d.main_idx   = RES_IDX_W'(main_idx_q);
          res_d.slave_idx  = RES_IDX_W'(core_index);
          res_d.main_coor  = core_main_q[COOR_MSB:COOR_LSB];
          res_d.slave_coor = core_coor;
          res_d.hd         = core_min_hd;
          if (core_min_hd <= HD_THRESH) begin
            state_d     = EMIT;
            res_valid_d = 1'b1;
          end else begin
            state_d = NEXT;
          end
        end
      end
      EMIT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          res_cnt_d   = res_cnt_q + IDX_W'(1);
          state_d     = NEXT;
        end
      end
      NEXT: begin
        if (main_idx_q == n_main_q - IDX_W'(1)) begin
          state_d = FIN;
        end else begin
          main_idx_d  = main_idx_q + IDX_W'(1);
          state_d     = MAIN_RD;
          main_rd_d   = 1'b1;
          main_addr_d = main_idx_q + IDX_W'(1);
        end
      end
      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      n_main_q     <= '0;
      n_slave_q    <= '0;
      main_idx_q   <= '0;
      res_cnt_q    <= '0;
      main_addr_q  <= '0;
      slave_addr_q <= '0;
      main_rd_q    <= 1'b0;
      slave_rd_q   <= 1'b0;
      core_en_q    <= 1'b0;
      core_clear_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      res_valid_q  <= 1'b0;
      core_main_q  <= '0;
      res_q        <= '0;
    end else begin
      state_q      <= state_d;
      n_main_q     <= n_main_d;
      n_slave_q    <= n_slave_d;
      main_idx_q   <= main_idx_d;
      res_cnt_q    <= res_cnt_d;
      main_addr_q  <= main_addr_d;
      slave_addr_q <= slave_addr_d;
      main_rd_q    <= main_rd_d;
      slave_rd_q   <= slave_rd_d;
      core_en_q    <= core_en_d;
      core_clear_q <= core_clear_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      res_valid_q  <= res_valid_d;
      core_main_q  <= core_main_d;
      res_q        <= res_d;
    end
  end

  assign main_rd        = main_rd_q;
  assign main_addr      = main_addr_q;
  assign slave_rd       = slave_rd_q;
  assign slave_addr     = slave_addr_q;
  assign core_en        = core_en_q;
  assign core_clear     = core_clear_q;
  assign core_main      = core_main_q;
  assign core_slave     = slave_rdata;
  assign res_valid      = res_valid_q;
  assign res_main_idx   = IDX_W'(res_q.main_idx);
  assign res_slave_idx  = IDX_W'(res_q.slave_idx);
  assign res_main_coor  = res_q.main_coor;
  assign res_slave_coor = res_q.slave_coor;
  assign res_hd         = res_q.hd;
  assign res_cnt        = res_cnt_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: doc/match_scheduler.md
Name: match_scheduler

Overview:
- Sequences one match_core instance over a main-vs-slave descriptor set.
- For each main descriptor it:
  - fetches the main descriptor;
  - clears the core;
  - streams all slave descriptors into the core;
  - waits for the core's done pulse;
  - emits a thresholded match result on a valid/ready port.
- Sits between the two descriptor RAMs (148-bit words, coordinate in [147:128]) and the downstream match-pair FIFO.

Parameters:
- IDX_W, 10, width of main/slave indices and counts.
- HD_THRESH, 8'd64, maximum accepted Hamming distance; matches with hd > HD_THRESH are dropped.
- DESC_W, 148, descriptor word width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse; begin a run using n_main/n_slave
- n_main  in  IDX_W  number of main descriptors, sampled at start
- n_slave  in  IDX_W  number of slave descriptors, sampled at start
- main_rd  out  1  main RAM read strobe
- main_addr  out  IDX_W  main RAM address
- main_rdata  in  DESC_W  main RAM data, valid 1 cycle after main_rd
- slave_rd  out  1  slave RAM read strobe
- slave_addr  out  IDX_W  slave RAM address
- slave_rdata  in  DESC_W  slave RAM data, valid 1 cycle after slave_rd
- core_en  out  1  to match_core en
- core_clear  out  1  to match_core clear
- core_main  out  DESC_W  latched main descriptor to the core
- core_slave  out  DESC_W  slave descriptor to the core (slave_rdata passthrough)
- core_index  in  IDX_W  match_core index_Slave
- core_coor  in  20  match_core coor_Slave
- core_min_hd  in  8  match_core min_hd
- core_done  in  1  match_core done
- res_valid  out  1  result valid
- res_ready  in  1  downstream ready
- res_main_idx  out  IDX_W  index of the main descriptor
- res_slave_idx  out  IDX_W  best slave index
- res_main_coor  out  20  main coordinate
- res_slave_coor  out  20  best slave coordinate
- res_hd  out  8  best Hamming distance
- res_cnt  out  IDX_W  results emitted in this run
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at end of run

Behaviour:
- Reset (asynchronous, any state): FSM to IDLE; all outputs and counters 0; core_main cleared to 0.
- FSM states: IDLE, MAIN_RD, CLEAR, STREAM, DRAIN, EMIT, NEXT, FIN.
- IDLE:
  - start=1 latches n_main/n_slave, clears main_idx and res_cnt, sets busy.
  - Goes to MAIN_RD, or to FIN if n_main==0.
  - start while busy is ignored.
- MAIN_RD: main_rd=1, main_addr=main_idx, for one cycle.
- CLEAR:
  - Latches main_rdata into core_main; core_clear=1 for exactly this cycle.
  - Goes to NEXT if n_slave==0, else STREAM with slave_idx=0.
- STREAM:
  - slave_rd=1, slave_addr=slave_idx, one address per cycle with no bubbles.
  - After issuing address n_slave-1, goes to DRAIN.
- core_en is slave_rd delayed one register, so it aligns with slave_rdata and is contiguous for exactly n_slave cycles. The core therefore raises done exactly once per main descriptor.
- core_main is stable from CLEAR until the next CLEAR.
- DRAIN:
  - Waits for core_done, then samples core_index, core_coor and core_min_hd into the result registers, with main_coor = core_main[147:128].
  - Goes to EMIT if core_min_hd <= HD_THRESH, else NEXT (result dropped).
- EMIT:
  - res_valid=1; result fields are held stable until res_ready.
  - On the valid&ready cycle: res_cnt+1, go to NEXT. res_valid never drops without a handshake.
- NEXT: main_idx+1; goes to MAIN_RD, or to FIN if main_idx==n_main-1.
- FIN: done=1 for one cycle, busy=0, go to IDLE. res_cnt holds until the next start.
- Per-main latency with res_ready=1: 1 (MAIN_RD) + 1 (CLEAR) + n_slave (STREAM) + core pipeline (~4) + 1 (EMIT) + 1 (NEXT).
- Ties are resolved by the core (first minimum wins); the scheduler does not reorder.
- Index width: n_slave up to 2^IDX_W-1; counters wrap only beyond that, which is out of range.

Decomposition:
- Shared package match_pkg holds:
  - state enum;
  - DESC_W, COOR_MSB=147, COOR_LSB=128;
  - HD width 8;
  - a result struct {main_idx, slave_idx, main_coor, slave_coor, hd}.
- No sub-module; the FSM, counters and result register live in one file. match_core is instantiated at the level above.

Test Plan:
- Single pair: n_main=1, n_slave=3, slave hd {40,12,12}, res_ready=1 -> one result: slave_idx=1, hd=12, res_cnt=1, done pulse; core_en high exactly 3 consecutive cycles.
- Threshold: n_main=2; main0 best hd=70, main1 best hd=64 -> only main1 emitted (res_main_idx=1, hd=64), res_cnt=1.
- Backpressure: res_ready=0 for 10 cycles during EMIT -> res_valid stays 1 with all fields constant, no next MAIN_RD until the handshake.
- Empty sets: n_main=0 -> done 2 cycles after start, no RAM reads; n_slave=0, n_main=2 -> no core_en, no results, done pulse.
- Reset mid-STREAM: rst_n low while slave_addr=5 -> all outputs 0 immediately; after release, start with n_main=1, n_slave=2 completes normally.
- Start ignored: second start pulse while busy -> no restart; main_addr sequence and res_cnt unaffected.
